// File: rtl/tb_mem_model.sv
// Behavioural-but-synthesizable memory model for core testbenches.
//
// A word-addressed array with byte strobes, a fixed-latency in-order response pipeline and a
// "tohost" halt mailbox. One request per cycle; the only back-pressure is halt.
//
// Parameters:
//   XLEN        data/address width (32 or 64)
//   DEPTH       array size in XLEN-wide words (power of 2)
//   RD_LAT      response latency in cycles (1..4)
//   BASE_ADDR   byte address of array word 0
//   TOHOST_ADDR byte address of the halt mailbox (outside the array)
//
// Ports:
//   clk, reset (synchronous, active low)
//   req_valid/req_ready handshake; req_we, req_be, req_addr, req_wdata request payload
//   rsp_valid, rsp_rdata, rsp_err response (rsp_rdata is 0 whenever rsp_valid is 0)
//   halt, tohost_data mailbox status; req_count saturating count of accepted requests
module tb_mem_model #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned RD_LAT      = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter logic [63:0] TOHOST_ADDR = 64'h0000_0000_8000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [XLEN/8-1:0] req_be,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              halt,
    output logic [XLEN-1:0]   tohost_data,
    output logic [31:0]       req_count
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] BASE   = BASE_ADDR[XLEN-1:0];
    localparam logic [XLEN-1:0] TOHOST = TOHOST_ADDR[XLEN-1:0];

    logic [XLEN-1:0] mem_q [DEPTH];

    logic            vld_q [RD_LAT];
    logic            err_q [RD_LAT];
    logic [XLEN-1:0] dat_q [RD_LAT];

    logic            halt_q;
    logic [XLEN-1:0] tohost_q;
    logic [31:0]     count_q, count_d;

    logic            accept;
    logic [XLEN-1:0] offset;
    logic [IDXW-1:0] idx;
    logic            misaligned, out_of_range, is_tohost, be_full;
    logic            req_err, tohost_wr, mem_wr;
    logic [XLEN-1:0] stage0_data;

    assign req_ready = reset && !halt_q;
    assign accept    = req_valid && req_ready;

    // Address decode
    assign offset       = req_addr - BASE;
    assign idx          = offset[OFFW +: IDXW];
    assign misaligned   = |req_addr[OFFW-1:0];
    assign out_of_range = (offset >> OFFW) >= XLEN'(DEPTH);
    assign is_tohost    = (req_addr == TOHOST);
    assign be_full      = &req_be;

    // The mailbox only accepts full-word writes; anything partial there is an error.
    assign req_err   = is_tohost ? (req_we && !be_full) : (misaligned || out_of_range);
    assign tohost_wr = accept && req_we && is_tohost && be_full;
    assign mem_wr    = accept && req_we && !is_tohost && !req_err;

    // Read data is sampled at acceptance; writes and errors respond with zero data.
    always_comb begin
        stage0_data = '0;
        if (accept && !req_we && !req_err) begin
            stage0_data = is_tohost ? tohost_q : mem_q[idx];
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Array is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                err_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
            halt_q   <= 1'b0;
            tohost_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q[0] <= accept;
            err_q[0] <= accept && req_err;
            dat_q[0] <= stage0_data;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            if (tohost_wr) begin
                halt_q   <= 1'b1;
                tohost_q <= req_wdata;
            end
            count_q <= count_d;
        end
    end

    assign rsp_valid   = vld_q[RD_LAT-1];
    assign rsp_err     = err_q[RD_LAT-1];
    assign rsp_rdata   = dat_q[RD_LAT-1];
    assign halt        = halt_q;
    assign tohost_data = tohost_q;
    assign req_count   = count_q;

endmodule

// File: tb/tb_tb_mem_model.sv
// Directed self-checking bench for tb_mem_model at default parameters
// (XLEN=64, DEPTH=4096, RD_LAT=2, BASE_ADDR=0, TOHOST_ADDR=0x8000_1000).
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_tb_mem_model;

    localparam logic [63:0] TOHOST = 64'h0000_0000_8000_1000;
    localparam logic [63:0] DEAD   = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] W0     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W1     = 64'hFEDC_BA98_7654_3210;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_be;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        halt;
    logic [63:0] tohost_data;
    logic [31:0] req_count;

    int n_vec;
    int n_err;

    tb_mem_model dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .halt       (halt),
        .tohost_data(tohost_data),
        .req_count  (req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] be, input logic [63:0] addr,
                         input logic [63:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        repeat (3) step();
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL rst_halt: got %b want 0", halt); end
        n_vec++; if (tohost_data !== 64'h0) begin n_err++; $display("FAIL rst_tohost: got %h want 0", tohost_data); end
        n_vec++; if (req_count !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", req_count); end
    endtask

    // Write then read the same word back-to-back; first request issued with reset release.
    task automatic test_write_read();
        reset = 1'b1;
        drive(1'b1, 8'hFF, 64'h10, DEAD);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_first_ready: got %b want 1", req_ready); end
        step();
        n_vec++; if (req_count !== 32'd1) begin n_err++; $display("FAIL wr_count1: got %0d want 1", req_count); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_early_valid: got %b want 0", rsp_valid); end
        drive(1'b0, 8'h00, 64'h10, 64'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL wr_rsp_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL wr_rsp_err: got %b want 0", rsp_err); end
        n_vec++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL wr_rsp_rdata: got %h want 0", rsp_rdata); end
        drive(1'b1, 8'hFF, 64'h0, W0);
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
        n_vec++; if (rsp_rdata !== DEAD) begin n_err++; $display("FAIL rd_after_wr: got %h want %h", rsp_rdata, DEAD); end
        drive(1'b1, 8'hFF, 64'h8, W1);
        step();
        idle();
        step();
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_drain_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL wr_drain_rdata: got %h want 0", rsp_rdata); end
        n_vec++; if (req_count !== 32'd4) begin n_err++; $display("FAIL wr_count4: got %0d want 4", req_count); end
    endtask

    task automatic test_back_to_back();
        reset = 1'b0;
        step();
        step();
        n_vec++; if (req_count !== 32'd0) begin n_err++; $display("FAIL b2b_count_rst: got %0d want 0", req_count); end
        reset = 1'b1;
        drive(1'b0, 8'h00, 64'h0, 64'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early: got %b want 0", rsp_valid); end
        drive(1'b0, 8'h00, 64'h8, 64'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_v0: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== W0) begin n_err++; $display("FAIL b2b_d0: got %h want %h", rsp_rdata, W0); end
        drive(1'b0, 8'h00, 64'h10, 64'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_v1: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== W1) begin n_err++; $display("FAIL b2b_d1: got %h want %h", rsp_rdata, W1); end
        idle();
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_v2: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== DEAD) begin n_err++; $display("FAIL b2b_d2: got %h want %h", rsp_rdata, DEAD); end
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", rsp_valid); end
        n_vec++; if (req_count !== 32'd3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", req_count); end
    endtask

    task automatic test_partial();
        drive(1'b1, 8'hFF, 64'h18, 64'h0);
        step();
        drive(1'b1, 8'h0F, 64'h18, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        drive(1'b1, 8'hFF, 64'h20, 64'h0);
        step();
        drive(1'b1, 8'hA5, 64'h20, 64'h1122_3344_5566_7788);
        step();
        drive(1'b0, 8'h00, 64'h18, 64'h0);
        step();
        drive(1'b0, 8'h00, 64'h20, 64'h0);
        step();
        n_vec++; if (rsp_rdata !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL be_0f: got %h want 00000000ffffffff", rsp_rdata); end
        idle();
        step();
        n_vec++; if (rsp_rdata !== 64'h1100_3300_0066_0088) begin n_err++; $display("FAIL be_a5: got %h want 1100330000660088", rsp_rdata); end
        step();
        n_vec++; if (req_count !== 32'd9) begin n_err++; $display("FAIL be_count: got %0d want 9", req_count); end
    endtask

    task automatic test_errors();
        drive(1'b0, 8'h00, 64'h4, 64'h0);
        step();
        drive(1'b0, 8'h00, 64'h8000, 64'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_err++; $display("FAIL err_misal: got v=%b e=%b want v=1 e=1", rsp_valid, rsp_err); end
        n_vec++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL err_misal_data: got %h want 0", rsp_rdata); end
        drive(1'b1, 8'hFF, 64'h14, 64'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_err++; $display("FAIL err_oob: got v=%b e=%b want v=1 e=1", rsp_valid, rsp_err); end
        n_vec++; if (rsp_rdata !== 64'h0) begin n_err++; $display("FAIL err_oob_data: got %h want 0", rsp_rdata); end
        drive(1'b1, 8'h0F, TOHOST, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL err_misal_wr: got %b want 1", rsp_err); end
        drive(1'b0, 8'h00, 64'h10, 64'h0);
        step();
        n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL err_tohost_part: got %b want 1", rsp_err); end
        n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL err_tohost_halt: got %b want 0", halt); end
        n_vec++; if (tohost_data !== 64'h0) begin n_err++; $display("FAIL err_tohost_data: got %h want 0", tohost_data); end
        idle();
        step();
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL err_intact_err: got %b want 0", rsp_err); end
        n_vec++; if (rsp_rdata !== DEAD) begin n_err++; $display("FAIL err_intact: got %h want %h", rsp_rdata, DEAD); end
        step();
        n_vec++; if (req_count !== 32'd14) begin n_err++; $display("FAIL err_count: got %0d want 14", req_count); end
    endtask

    task automatic test_halt();
        drive(1'b0, 8'h00, TOHOST, 64'h0);
        step();
        drive(1'b1, 8'hFF, TOHOST, 64'h1);
        step();
        n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b want 1", halt); end
        n_vec++; if (tohost_data !== 64'h1) begin n_err++; $display("FAIL halt_data: got %h want 1", tohost_data); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL halt_ready: got %b want 0", req_ready); end
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL tohost_rd: got v=%b e=%b want v=1 e=0", rsp_valid, rsp_err); end
        drive(1'b0, 8'h00, 64'h10, 64'h0);
        step();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_err++; $display("FAIL halt_wr_rsp: got v=%b e=%b want v=1 e=0", rsp_valid, rsp_err); end
        n_vec++; if (req_count !== 32'd16) begin n_err++; $display("FAIL halt_count: got %0d want 16", req_count); end
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL halt_blocked: got %b want 0", rsp_valid); end
        idle();
        step();
        n_vec++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", halt); end
    endtask

    task automatic test_reset_flush();
        reset = 1'b0;
        step();
        n_vec++; if (halt !== 1'b0) begin n_err++; $display("FAIL flush_halt_clr: got %b want 0", halt); end
        reset = 1'b1;
        drive(1'b0, 8'h00, 64'h0, 64'h0);
        step();
        drive(1'b0, 8'h00, 64'h8, 64'h0);
        step();
        n_vec++; if (rsp_rdata !== W0) begin n_err++; $display("FAIL flush_d0: got %h want %h", rsp_rdata, W0); end
        drive(1'b0, 8'h00, 64'h10, 64'h0);
        step();
        idle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_in_rst%0d: got %b want 0", i, rsp_valid); end
        end
        n_vec++; if (req_count !== 32'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", req_count); end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (rsp_valid !== 1'b0 || rsp_rdata !== 64'h0) begin n_err++; $display("FAIL flush_after%0d: got v=%b d=%h want v=0 d=0", i, rsp_valid, rsp_rdata); end
        end
        drive(1'b0, 8'h00, 64'h10, 64'h0);
        step();
        idle();
        step();
        n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== DEAD) begin n_err++; $display("FAIL flush_keep: got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_rdata, DEAD); end
        n_vec++; if (req_count !== 32'd1) begin n_err++; $display("FAIL flush_count1: got %0d want 1", req_count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_partial();
        test_errors();
        test_halt();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
